// File: rtl/brg_cgra_xcel_host_driver.sv
// brg_cgra_xcel_host_driver: turns store/load/fence commands into manycore requests under a credit limit and buffers returned load data.
// Optional watchdog enabled by defining BRG_CGRA_HOST_DRIVER_TIMEOUT_EN.
module brg_cgra_xcel_host_driver #(
  parameter int addr_width_p      = 28,
  parameter int data_width_p      = 32,
  parameter int x_cord_width_p    = 7,
  parameter int y_cord_width_p    = 7,
  parameter int max_out_credits_p = 16,
  parameter int fwd_pkt_width_lp  = addr_width_p + 11 + data_width_p + 2 * (x_cord_width_p + y_cord_width_p),
  parameter int rev_pkt_width_lp  = 7 + data_width_p + x_cord_width_p + y_cord_width_p,
  parameter int link_sif_width_lp = fwd_pkt_width_lp + rev_pkt_width_lp + 4,
  parameter int credit_width_lp   = $clog2(max_out_credits_p + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         cmd_v_i,
  input  logic [1:0]                   cmd_op_i,
  input  logic [addr_width_p-1:0]      cmd_addr_i,
  input  logic [data_width_p-1:0]      cmd_data_i,
  input  logic [x_cord_width_p-1:0]    cmd_x_i,
  input  logic [y_cord_width_p-1:0]    cmd_y_i,
  output logic                         cmd_ready_o,
  input  logic [x_cord_width_p-1:0]    my_x_i,
  input  logic [y_cord_width_p-1:0]    my_y_i,
  input  logic [link_sif_width_lp-1:0] link_sif_i,
  output logic [link_sif_width_lp-1:0] link_sif_o,
  output logic                         load_v_o,
  output logic [data_width_p-1:0]      load_data_o,
  input  logic                         load_yumi_i,
  output logic [credit_width_lp-1:0]   out_credits_o,
  output logic                         idle_o,
  output logic                         err_o
);
  typedef struct packed {
    logic [addr_width_p-1:0]   addr;
    logic [1:0]                op;
    logic [4:0]                reg_id;
    logic [3:0]                mask;
    logic [data_width_p-1:0]   payload;
    logic [y_cord_width_p-1:0] src_y;
    logic [x_cord_width_p-1:0] src_x;
    logic [y_cord_width_p-1:0] y_cord;
    logic [x_cord_width_p-1:0] x_cord;
  } fwd_pkt_s;
  typedef struct packed {
    logic [1:0]                pkt_type;
    logic [data_width_p-1:0]   data;
    logic [4:0]                reg_id;
    logic [y_cord_width_p-1:0] y_cord;
    logic [x_cord_width_p-1:0] x_cord;
  } rev_pkt_s;
  typedef struct packed {
    logic     fwd_v;
    fwd_pkt_s fwd_pkt;
    logic     fwd_ready;
    logic     rev_v;
    rev_pkt_s rev_pkt;
    logic     rev_ready;
  } link_sif_s;
  typedef enum logic [1:0] {IDLE, ISSUE, FENCE} state_e;
  localparam logic [1:0] op_load_lp = 2'd0;
  localparam logic [1:0] op_store_lp = 2'd1;
  localparam logic [1:0] ret_int_wb_lp = 2'd1;
  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);
  link_sif_s li, lo;
  state_e state, state_n;
  fwd_pkt_s pkt_r, pkt_n;
  logic [credit_width_lp-1:0] credits;
  logic [data_width_p-1:0] fifo_mem [2];
  logic wr_ptr, rd_ptr;
  logic [1:0] count;
  logic err, wd_err, accept, fwd_fire, rev_fire, push, pop, credit_full, overflow, bad_op;
  logic unused;
  assign li = link_sif_i;
  assign link_sif_o = lo;
  assign unused = ^{li.fwd_pkt, li.rev_ready, li.rev_pkt};
  assign credit_full = credits == max_credits_lp;
  assign cmd_ready_o = (state == IDLE) & ((credits != '0) | (cmd_op_i == 2'b10));
  assign accept = cmd_v_i & cmd_ready_o;
  assign bad_op = accept & (cmd_op_i == 2'b11);
  assign fwd_fire = (state == ISSUE) & li.fwd_ready;
  // rev ready looks only at the registered occupancy, never at load_yumi_i
  assign rev_fire = li.rev_v & (count != 2'd2);
  assign push = rev_fire & (li.rev_pkt.pkt_type == ret_int_wb_lp);
  assign pop = load_yumi_i & (count != 2'd0);
  assign overflow = rev_fire & ~fwd_fire & credit_full;
  assign pkt_n = '{addr: cmd_addr_i, op: cmd_op_i[0] ? op_load_lp : op_store_lp, reg_id: '0, mask: 4'hF,
                   payload: cmd_op_i[0] ? '0 : cmd_data_i, src_y: my_y_i, src_x: my_x_i,
                   y_cord: cmd_y_i, x_cord: cmd_x_i};
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = !accept ? IDLE : (cmd_op_i == 2'b10) ? FENCE : cmd_op_i[1] ? IDLE : ISSUE;
    else if (state == ISSUE) state_n = li.fwd_ready ? IDLE : ISSUE;
    else state_n = credit_full ? IDLE : FENCE;
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state   <= IDLE;
      pkt_r   <= '0;
      credits <= max_credits_lp;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      err     <= 1'b0;
    end else begin
      state <= state_n;
      if (accept && !cmd_op_i[1]) pkt_r <= pkt_n;
      if (fwd_fire && !rev_fire) credits <= credits - credit_width_lp'(1);
      else if (rev_fire && !fwd_fire && !credit_full) credits <= credits + credit_width_lp'(1);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
      err <= err | bad_op | overflow | li.fwd_v | wd_err;
    end
  end
  always_ff @(posedge clk_i) if (push) fifo_mem[wr_ptr] <= li.rev_pkt.data;
`ifdef BRG_CGRA_HOST_DRIVER_TIMEOUT_EN
  logic [15:0] wd;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) wd <= '0;
    else if (rev_fire || credit_full) wd <= '0;
    else if (wd != 16'hFFFF) wd <= wd + 16'd1;
  end
  assign wd_err = wd == 16'hFFFF;
`else
  assign wd_err = 1'b0;
`endif
  assign lo = '{fwd_v: state == ISSUE, fwd_pkt: pkt_r, fwd_ready: 1'b1, rev_v: 1'b0, rev_pkt: '0,
                rev_ready: count != 2'd2};
  assign load_v_o = count != 2'd0;
  assign load_data_o = fifo_mem[rd_ptr];
  assign out_credits_o = credits;
  assign idle_o = (state == IDLE) & credit_full & (count == 2'd0);
  assign err_o = err;
endmodule
